// File: rtl/tt_proj_mux_ctrl.sv
// tt_proj_mux_ctrl: hosts NUM_PROJ user project slots behind one shared pad bus.
// Broadcasts the pad input word to all slots, enables at most one slot, and
// registers the selected slot's output word back onto the pads. Switching is
// sequenced (drain, then reset hold) so no slot sees a glitched ena or rst_n.
//
// state  | meaning
// -------+-------------------------------------------------------------
// OFF    | no slot enabled, waiting for a request
// SWITCH | drain: all ena low for DRAIN_CYCLES
// HOLD   | target ena high, project rst_n forced low for RST_CYCLES
// ACTIVE | target slot running, its outputs routed to the pads

module tt_proj_mux_ctrl #(
    parameter int NUM_PROJ     = 4,
    parameter int SEL_W        = 4,
    parameter int IW_W         = 18,
    parameter int OW_W         = 24,
    parameter int DRAIN_CYCLES = 2,
    parameter int RST_CYCLES   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel_valid,
    input  logic [SEL_W-1:0]         sel_id,
    output logic                     sel_ready,
    input  logic [IW_W-1:0]          iw_in,
    output logic [IW_W-1:0]          iw_out,
    output logic [NUM_PROJ-1:0]      ena_out,
    input  logic [NUM_PROJ*OW_W-1:0] ow_in,
    output logic [OW_W-1:0]          ow_out,
    output logic [SEL_W-1:0]         active_id,
    output logic                     busy
);

    localparam int CNT_MAX = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SWITCH = 2'd1,
        ST_HOLD   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [SEL_W-1:0]    target, target_nxt;
    logic [SEL_W-1:0]    active_nxt;
    logic [NUM_PROJ-1:0] ena_nxt;
    logic [NUM_PROJ-1:0] target_onehot;
    logic [OW_W-1:0]     ow_nxt;
    logic [OW_W-1:0]     sel_ow;
    logic                accept;
    logic                target_ok;

    assign sel_ready = (state == ST_OFF) || (state == ST_ACTIVE);
    assign busy      = (state == ST_SWITCH) || (state == ST_HOLD);
    assign accept    = sel_valid && sel_ready;
    assign target_ok = int'(target) < NUM_PROJ;

    // Decode the latched target into a one-hot enable and mux the active slot's outputs.
    always_comb begin
        target_onehot = '0;
        sel_ow        = '0;
        for (int k = 0; k < NUM_PROJ; k++) begin
            target_onehot[k] = (target == SEL_W'(k));
            if (active_id == SEL_W'(k)) begin
                sel_ow = ow_in[k*OW_W +: OW_W];
            end
        end
    end

    // Pad input broadcast: project clock always passes, rst_n only runs in ACTIVE,
    // data bits are gated off while no slot is enabled.
    always_comb begin
        iw_out    = '0;
        iw_out[0] = iw_in[0];
        iw_out[1] = (state == ST_ACTIVE) ? iw_in[1] : 1'b0;
        if ((state == ST_HOLD) || (state == ST_ACTIVE)) begin
            iw_out[IW_W-1:2] = iw_in[IW_W-1:2];
        end
    end

    // Next-state, counter, enable and output-word logic.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        target_nxt = target;
        active_nxt = active_id;
        ena_nxt    = ena_out;
        case (state)
            ST_OFF, ST_ACTIVE: begin
                if (accept) begin
                    state_nxt  = ST_SWITCH;
                    target_nxt = sel_id;
                    cnt_nxt    = CNT_W'(DRAIN_CYCLES);
                    ena_nxt    = '0;
                end
            end
            ST_SWITCH: begin
                if (cnt <= CNT_W'(1)) begin
                    if (target_ok) begin
                        state_nxt  = ST_HOLD;
                        ena_nxt    = target_onehot;
                        active_nxt = target;
                        cnt_nxt    = CNT_W'(RST_CYCLES);
                    end else begin
                        state_nxt = ST_OFF;
                        ena_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_OFF;
                ena_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
        // Clearing on the accepting edge keeps the old slot's data off the pads
        // for the whole drain, not just from the second SWITCH cycle on.
        ow_nxt = ((state == ST_ACTIVE) && !accept) ? sel_ow : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OFF;
            cnt       <= '0;
            target    <= '0;
            active_id <= '0;
            ena_out   <= '0;
            ow_out    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            target    <= target_nxt;
            active_id <= active_nxt;
            ena_out   <= ena_nxt;
            ow_out    <= ow_nxt;
        end
    end

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// Directed bench for tt_proj_mux_ctrl with the default parameters
// (4 slots, 2 drain cycles, 8 reset-hold cycles).

module tb_tt_proj_mux_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_valid;
    logic [3:0]  sel_id;
    logic        sel_ready;
    logic [17:0] iw_in;
    logic [17:0] iw_out;
    logic [3:0]  ena_out;
    logic [95:0] ow_in;
    logic [23:0] ow_out;
    logic [3:0]  active_id;
    logic        busy;

    int n_vec    = 0;
    int n_err    = 0;
    int busy_cnt = 0;

    tt_proj_mux_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .sel_valid (sel_valid),
        .sel_id    (sel_id),
        .sel_ready (sel_ready),
        .iw_in     (iw_in),
        .iw_out    (iw_out),
        .ena_out   (ena_out),
        .ow_in     (ow_in),
        .ow_out    (ow_out),
        .active_id (active_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        if (busy) busy_cnt++;
    endtask

    // Issue a one-cycle request and walk the whole drain/hold sequence.
    task automatic do_select(input logic [3:0] id, input logic [3:0] prev_active);
        logic [31:0] exp_ena;
        bit          ok;
        ok      = (id < 4'd4);
        exp_ena = ok ? (32'd1 << id) : 32'h0;
        busy_cnt = 0;
        sel_valid = 1'b1;
        sel_id    = id;
        step();
        sel_valid = 1'b0;
        sel_id    = 4'd0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) step();
            #1;
            chk("drain_ena",   32'(ena_out),   32'h0);
            chk("drain_ready", 32'(sel_ready), 32'h0);
            chk("drain_iw",    32'(iw_out),    32'h1);
            chk("drain_ow",    32'(ow_out),    32'h0);
            chk("drain_aid",   32'(active_id), 32'(prev_active));
        end
        if (ok) begin
            for (int h = 0; h < 8; h++) begin
                step();
                sel_valid = 1'b0;
                #1;
                chk("hold_ena",    32'(ena_out),   exp_ena);
                chk("hold_hot",    32'($countones(ena_out)), 32'h1);
                chk("hold_iw",     32'(iw_out),    32'h3FFFD);
                chk("hold_ow",     32'(ow_out),    32'h0);
                chk("hold_aid",    32'(active_id), 32'(id));
                chk("hold_ready",  32'(sel_ready), 32'h0);
                if (h == 3) begin
                    sel_valid = 1'b1;
                    sel_id    = id + 4'd1;
                end
            end
            sel_valid = 1'b0;
            step();
            #1;
            chk("act_busy",  32'(busy),      32'h0);
            chk("act_ready", 32'(sel_ready), 32'h1);
            chk("act_ena",   32'(ena_out),   exp_ena);
            chk("act_aid",   32'(active_id), 32'(id));
            chk("act_iw",    32'(iw_out),    32'h3FFFF);
            chk("busy_len",  32'(busy_cnt),  32'd10);
        end else begin
            step();
            #1;
            chk("off_busy",  32'(busy),      32'h0);
            chk("off_ready", 32'(sel_ready), 32'h1);
            chk("off_ena",   32'(ena_out),   32'h0);
            chk("off_ow",    32'(ow_out),    32'h0);
            chk("off_iw",    32'(iw_out),    32'h1);
            chk("off_aid",   32'(active_id), 32'(prev_active));
            chk("busy_len",  32'(busy_cnt),  32'd2);
        end
    endtask

    initial begin
        rst       = 1'b1;
        sel_valid = 1'b0;
        sel_id    = 4'd0;
        iw_in     = 18'h3FFFF;
        ow_in     = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_ena",   32'(ena_out),   32'h0);
        chk("rst_ow",    32'(ow_out),    32'h0);
        chk("rst_aid",   32'(active_id), 32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_ready", 32'(sel_ready), 32'h1);
        chk("rst_iw",    32'(iw_out),    32'h1);
        step();
        #1;
        chk("off_idle_ena", 32'(ena_out), 32'h0);

        do_select(4'd2, 4'd0);

        ow_in[48 +: 24] = 24'hA5C3F0;
        step();
        #1;
        chk("ow_slot2", 32'(ow_out), 32'hA5C3F0);
        ow_in[24 +: 24] = 24'h123456;
        step();
        #1;
        chk("ow_slot1_ignored", 32'(ow_out), 32'hA5C3F0);
        ow_in[48 +: 24] = 24'h0F0F0F;
        step();
        #1;
        chk("ow_slot2_upd", 32'(ow_out), 32'h0F0F0F);
        iw_in = 18'h3FFFD;
        #1;
        chk("iw_rstn_follow", 32'(iw_out), 32'h3FFFD);
        iw_in = 18'h3FFFF;
        #1;

        do_select(4'd1, 4'd2);
        step();
        #1;
        chk("ow_slot1", 32'(ow_out), 32'h123456);

        do_select(4'd3, 4'd1);
        do_select(4'd3, 4'd3);

        ow_in[72 +: 24] = 24'hFFFFFF;
        do_select(4'd15, 4'd3);
        step();
        #1;
        chk("off_ow_hold", 32'(ow_out), 32'h0);
        chk("off_ena_hold", 32'(ena_out), 32'h0);

        sel_valid = 1'b1;
        sel_id    = 4'd2;
        step();
        sel_valid = 1'b0;
        step();
        step();
        step();
        step();
        step();
        #1;
        chk("hold4_ena", 32'(ena_out), 32'h4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_ena",   32'(ena_out),   32'h0);
        chk("abort_busy",  32'(busy),      32'h0);
        chk("abort_ow",    32'(ow_out),    32'h0);
        chk("abort_ready", 32'(sel_ready), 32'h1);
        chk("abort_aid",   32'(active_id), 32'h0);
        step();
        #1;
        chk("abort_stay_ena",  32'(ena_out), 32'h0);
        chk("abort_stay_busy", 32'(busy),    32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tt_proj_mux_ctrl.md
Name: tt_proj_mux_ctrl

Overview:
- Parametrised successor to the single-project tile wrapper. Hosts NUM_PROJ user project slots behind one shared pad bus.
- Unpacks the shared input word and broadcasts it to all slots. Asserts exactly one slot's ena. Registers the selected slot's output word back onto the pads.
- Project switching is sequenced: outputs are drained, the old slot is disabled, and the new slot is held in reset for a fixed interval. No slot ever sees a glitched ena or rst_n.

Parameters:
- NUM_PROJ, 4, number of project slots (2..16).
- SEL_W, 4, width of the slot id; must satisfy 2^SEL_W > NUM_PROJ.
- IW_W, 18, shared input word width. Bit 0 = project clk, bit 1 = project rst_n, the rest = ui_in/uio_in.
- OW_W, 24, per-slot output word width ({uio_oe, uio_out, uo_out}).
- DRAIN_CYCLES, 2, cycles with all ena low between slots (>=1).
- RST_CYCLES, 8, cycles the new slot is held with rst_n low (>=1).

Ports:
- clk  input  1  controller clock.
- rst  input  1  synchronous, active-high reset.
- sel_valid  input  1  slot-select request valid.
- sel_id  input  SEL_W  requested slot; any value >= NUM_PROJ means "no project".
- sel_ready  output  1  request accepted when sel_valid && sel_ready.
- iw_in  input  IW_W  packed word from the pads.
- iw_out  output  IW_W  word broadcast to all slots.
- ena_out  output  NUM_PROJ  one-hot-or-zero slot enables.
- ow_in  input  NUM_PROJ*OW_W  concatenated slot outputs; slot k occupies [k*OW_W +: OW_W].
- ow_out  output  OW_W  registered output to the pads.
- active_id  output  SEL_W  slot currently enabled (or the target during HOLD).
- busy  output  1  high in SWITCH and HOLD.

Behaviour:
- Reset (rst=1 at a clk edge): state OFF, ena_out=0, ow_out=0, active_id=0, busy=0, sel_ready=1, counters=0. rst mid-sequence aborts the sequence immediately to OFF.
- States:
  - OFF: no slot enabled.
  - SWITCH: drain, all ena low.
  - HOLD: target slot ena high, rst_n forced low.
  - ACTIVE: target slot running.
- sel_ready = 1 in OFF and ACTIVE, 0 in SWITCH and HOLD.
- Accept from OFF or ACTIVE → SWITCH. The target is latched and the counter is loaded with DRAIN_CYCLES. ena_out goes 0 on the next edge.
- SWITCH: counts down. At expiry:
  - valid target → HOLD with ena_out[target]=1 and the counter loaded with RST_CYCLES;
  - invalid target → OFF.
- HOLD: lasts exactly RST_CYCLES cycles, then → ACTIVE.
- Selecting the already-active id while ACTIVE is legal. It re-runs the full SWITCH/HOLD sequence and serves as a per-project reset.
- active_id updates on entry to HOLD. It holds its last value in OFF and SWITCH.
- ena_out is registered: at most one bit set, and it changes only at state transitions.
- iw_out, combinational from iw_in and state:
  - bit 0 (project clk) = iw_in[0] in all states;
  - bit 1 (rst_n) = iw_in[1] in ACTIVE, 0 otherwise;
  - bits [IW_W-1:2] = iw_in in HOLD and ACTIVE, 0 in OFF and SWITCH.
- ow_out is registered with 1-cycle latency: in ACTIVE, ow_out <= ow_in slice[active_id]; in every other state ow_out <= 0.
- sel_valid is ignored while sel_ready=0. The requester must hold sel_valid; no queueing.
- All counters are wide enough for max(DRAIN_CYCLES, RST_CYCLES) and never wrap.

Test Plan:
- Reset then sel_id=2 pulsed with valid → sel_ready drops next cycle. ena_out=0 for 2 cycles, then 4'b0100 with iw_out[1]=0 for 8 cycles, then ACTIVE with iw_out[1] following iw_in[1]. busy high for exactly 10 cycles.
- ACTIVE on slot 2 with ow_in slice2=24'hA5C3F0 → ow_out=24'hA5C3F0 one cycle later. Changing slice1 leaves ow_out unchanged.
- ACTIVE on slot 2, request slot 1 → ena_out 0100→0000 (2 cycles)→0010. ow_out reads 0 throughout SWITCH/HOLD. ena_out is never multi-hot.
- Request sel_id=15 with NUM_PROJ=4 → after drain the block sits in OFF, ena_out=0, ow_out=0, iw_out[17:1]=0, sel_ready=1.
- Re-select active slot 3 → ena_out[3] drops for 2 cycles, then an 8-cycle rst_n-low hold, then ACTIVE on slot 3.
- Assert rst during HOLD cycle 4 → next edge: OFF, ena_out=0, busy=0, ow_out=0. sel_valid pulses during busy are ignored, with no state change.
